// File: rtl/core_reset_pkg.sv
// core_reset_pkg: state encoding and default cycle constants for the core reset sequencer
package core_reset_pkg;
  typedef enum logic [2:0] {
    S_WAIT_LOCK,
    S_FILTER,
    S_CORE_HOLD,
    S_PERIPH_HOLD,
    S_RUN
  } state_t;
  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_LOCK_FILTER_CYCLES = 1024;
  localparam int DEF_CORE_HOLD_CYCLES = 16;
  localparam int DEF_PERIPH_DELAY_CYCLES = 64;
  localparam int DEF_LOST_CNT_WIDTH = 8;
  function automatic int max3(input int a, input int b, input int c);
    return (a > b) ? ((a > c) ? a : c) : ((b > c) ? b : c);
  endfunction
endpackage

// File: rtl/cdc_sync_bit.sv
// cdc_sync_bit: async-reset N-flop single-bit synchronizer (clk, resetn, d -> q), reset value 0
module cdc_sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic resetn,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] ff;
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) ff <= '0;
    else ff <= {ff[STAGES-2:0], d};
  assign q = ff[STAGES-1];
endmodule

// File: rtl/core_reset_ctrl.sv
// core_reset_ctrl: PLL-lock driven reset sequencer (clk, resetn, pll_locked, soft_reset_req -> core_reset, periph_reset, running, lock_lost_count)
module core_reset_ctrl
  import core_reset_pkg::*;
#(
  parameter int SYNC_STAGES         = DEF_SYNC_STAGES,
  parameter int LOCK_FILTER_CYCLES  = DEF_LOCK_FILTER_CYCLES,
  parameter int CORE_HOLD_CYCLES    = DEF_CORE_HOLD_CYCLES,
  parameter int PERIPH_DELAY_CYCLES = DEF_PERIPH_DELAY_CYCLES,
  parameter int LOST_CNT_WIDTH      = DEF_LOST_CNT_WIDTH
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      pll_locked,
  input  logic                      soft_reset_req,
  output logic                      core_reset,
  output logic                      periph_reset,
  output logic                      running,
  output logic [LOST_CNT_WIDTH-1:0] lock_lost_count
);
  localparam int CW = $clog2(max3(LOCK_FILTER_CYCLES, CORE_HOLD_CYCLES, PERIPH_DELAY_CYCLES)) + 1;
  logic                      locked_s;
  state_t                    state, state_n;
  logic [CW-1:0]             cnt, cnt_n;
  logic [LOST_CNT_WIDTH-1:0] lost_n;
  logic                      lose;
  cdc_sync_bit #(.STAGES(SYNC_STAGES)) u_sync (
    .clk   (clk),
    .resetn(resetn),
    .d     (pll_locked),
    .q     (locked_s)
  );
  // Lock loss only matters once the filter has passed; in S_FILTER it just restarts the wait.
  assign lose = !locked_s && (state inside {S_CORE_HOLD, S_PERIPH_HOLD, S_RUN});
  always_comb begin
    state_n = state;
    cnt_n   = cnt + 1'b1;
    lost_n  = lose ? ((&lock_lost_count) ? lock_lost_count : lock_lost_count + 1'b1) : lock_lost_count;
    case (state)
      S_WAIT_LOCK:   state_n = locked_s ? S_FILTER : S_WAIT_LOCK;
      S_FILTER:      state_n = !locked_s ? S_WAIT_LOCK :
                               (cnt == CW'(LOCK_FILTER_CYCLES)) ? S_CORE_HOLD : S_FILTER;
      S_CORE_HOLD:   state_n = lose ? S_WAIT_LOCK :
                               (cnt == CW'(CORE_HOLD_CYCLES - 1)) ? S_PERIPH_HOLD : S_CORE_HOLD;
      S_PERIPH_HOLD: state_n = lose ? S_WAIT_LOCK :
                               (cnt == CW'(PERIPH_DELAY_CYCLES - 1)) ? S_RUN : S_PERIPH_HOLD;
      S_RUN:         state_n = lose ? S_WAIT_LOCK : soft_reset_req ? S_CORE_HOLD : S_RUN;
      default:       state_n = S_WAIT_LOCK;
    endcase
    // Counter only advances in the timed states and restarts on every state entry.
    if (state_n != state || state inside {S_WAIT_LOCK, S_RUN}) cnt_n = '0;
  end
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      state           <= S_WAIT_LOCK;
      cnt             <= '0;
      lock_lost_count <= '0;
      core_reset      <= 1'b1;
      periph_reset    <= 1'b1;
      running         <= 1'b0;
    end else begin
      state           <= state_n;
      cnt             <= cnt_n;
      lock_lost_count <= lost_n;
      core_reset      <= state_n inside {S_WAIT_LOCK, S_FILTER, S_CORE_HOLD};
      periph_reset    <= state_n != S_RUN;
      running         <= state_n == S_RUN;
    end
endmodule
